// File: rtl/i2c_passthru_pkg.sv
// Shared definitions for the I2C passthru direction controller.
// State encoding, default byte width and bit-index helpers.
package i2c_passthru_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MST_START = 3'd1,
        ST_MST_WAIT  = 3'd2,
        ST_SLV_START = 3'd3,
        ST_SLV_WAIT  = 3'd4
    } state_t;

    localparam int DATA_BITS_DEF = 8;

    function automatic int ack_idx(input int data_bits);
        return data_bits + 1;
    endfunction

    function automatic int rw_idx(input int data_bits);
        return data_bits;
    endfunction

endpackage

// File: rtl/i2c_passthru_cond_det.sv
// START/STOP detector for one I2C channel.
// Compares SDA against its previous-cycle value while SCL is high.
module i2c_passthru_cond_det
    import i2c_passthru_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic start,
    output logic stop
);

    logic sda_q;

    // Idle bus is high, so no spurious START right after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_q <= 1'b1;
        end else begin
            sda_q <= sda;
        end
    end

    assign start = scl & sda_q & ~sda;
    assign stop  = scl & ~sda_q & sda;

endmodule

// File: rtl/i2c_passthru_dir_ctrl.sv
// Per-bit SDA direction and launch controller for the I2C passthru.
// Optional watchdog enabled by defining I2C_PASSTHRU_WDOG_EN.
module i2c_passthru_dir_ctrl
    import i2c_passthru_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int CNT_W     = 4,
    parameter int TMO_W     = 16,
    parameter int TMO_CYC   = 50000
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_cha_scl,
    input  logic             i_cha_sda,
    input  logic             i_chb_scl,
    input  logic             i_chb_sda,
    input  logic             i_rx_done,
    input  logic             i_tx_done,
    input  logic             i_rx_sda_init_valid,
    input  logic             i_rx_sda_init,
    output logic             o_start,
    output logic             o_slv_is_rx,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic             o_read_mode,
    output logic             o_ack_failed,
    output logic             o_restart,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] ACK_IDX = CNT_W'(ack_idx(DATA_BITS));
    localparam logic [CNT_W-1:0] RW_IDX  = CNT_W'(rw_idx(DATA_BITS));

    if ((2 ** CNT_W) <= DATA_BITS + 1 || TMO_CYC >= (2 ** TMO_W)) begin : g_cfg_err
        $error("i2c_passthru_dir_ctrl: CNT_W or TMO_W too small");
    end

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic [CNT_W-1:0] n_idx;
    logic             first_byte;
    logic             nxt_first;
    logic             read_mode;
    logic             nxt_rd;
    logic             ack_failed;
    logic             nxt_af;
    logic             nxt_restart;
    logic             is_ack;
    logic             slv_drv;
    logic             wd_hit;
    logic             start_a;
    logic             stop_a;
    logic             start_b;
    logic             stop_b;
    logic             start_any;
    logic             stop_any;

    i2c_passthru_cond_det u_det_a (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .scl   (i_cha_scl),
        .sda   (i_cha_sda),
        .start (start_a),
        .stop  (stop_a)
    );

    i2c_passthru_cond_det u_det_b (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .scl   (i_chb_scl),
        .sda   (i_chb_sda),
        .start (start_b),
        .stop  (stop_b)
    );

    assign start_any = start_a | start_b;
    assign stop_any  = stop_a | stop_b;

    // Index of the bit that the next launch will carry
    assign n_idx  = (bit_cnt == ACK_IDX) ? CNT_W'(1) : bit_cnt + CNT_W'(1);
    assign is_ack = (n_idx == ACK_IDX);

    always_comb begin
        nxt_state   = state;
        nxt_cnt     = bit_cnt;
        nxt_first   = first_byte;
        nxt_rd      = read_mode;
        nxt_af      = ack_failed;
        nxt_restart = 1'b0;
        slv_drv     = 1'b0;
        if (start_any) begin
            nxt_state   = ST_MST_START;
            nxt_cnt     = '0;
            nxt_first   = 1'b1;
            nxt_rd      = 1'b0;
            nxt_af      = 1'b0;
            nxt_restart = (state != ST_IDLE);
        end else if (stop_any || wd_hit) begin
            nxt_state = ST_IDLE;
            nxt_cnt   = '0;
        end else begin
            unique case (state)
                ST_MST_START, ST_SLV_START: begin
                    nxt_cnt   = n_idx;
                    if (bit_cnt == ACK_IDX) nxt_first = 1'b0;
                    nxt_state = (state == ST_SLV_START) ? ST_SLV_WAIT
                                                        : ST_MST_WAIT;
                end
                ST_MST_WAIT, ST_SLV_WAIT: begin
                    if (i_rx_sda_init_valid) begin
                        if (first_byte && bit_cnt == RW_IDX)
                            nxt_rd = i_rx_sda_init;
                        if (bit_cnt == ACK_IDX && i_rx_sda_init)
                            nxt_af = 1'b1;
                    end
                    // A sample taken this cycle already steers the next bit
                    if (first_byte && bit_cnt != ACK_IDX)
                        slv_drv = is_ack;
                    else if (nxt_af)
                        slv_drv = 1'b0;
                    else
                        slv_drv = nxt_rd ? !is_ack : is_ack;
                    if (i_rx_done && i_tx_done)
                        nxt_state = slv_drv ? ST_SLV_START : ST_MST_START;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            first_byte  <= 1'b1;
            read_mode   <= 1'b0;
            ack_failed  <= 1'b0;
            o_start     <= 1'b0;
            o_slv_is_rx <= 1'b0;
            o_busy      <= 1'b0;
            o_restart   <= 1'b0;
        end else begin
            state       <= nxt_state;
            bit_cnt     <= nxt_cnt;
            first_byte  <= nxt_first;
            read_mode   <= nxt_rd;
            ack_failed  <= nxt_af;
            o_start     <= (nxt_state == ST_MST_START) ||
                           (nxt_state == ST_SLV_START);
            o_slv_is_rx <= (nxt_state == ST_SLV_START) ||
                           (nxt_state == ST_SLV_WAIT);
            o_busy      <= (nxt_state != ST_IDLE);
            o_restart   <= nxt_restart;
        end
    end

    assign o_bit_cnt    = bit_cnt;
    assign o_read_mode  = read_mode;
    assign o_ack_failed = ack_failed;

`ifdef I2C_PASSTHRU_WDOG_EN
    logic [TMO_W-1:0] wd_cnt;
    logic             wd_clr;

    assign wd_hit = (wd_cnt == TMO_W'(TMO_CYC - 1));
    // Cleared as each launch is registered, so the count runs from o_start
    assign wd_clr = start_any | stop_any | (state == ST_IDLE) |
                    (nxt_state == ST_MST_START) |
                    (nxt_state == ST_SLV_START);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wd_cnt    <= '0;
            o_timeout <= 1'b0;
        end else begin
            wd_cnt    <= wd_clr ? '0 : wd_cnt + TMO_W'(1);
            o_timeout <= wd_hit & ~start_any & ~stop_any;
        end
    end
`else
    assign wd_hit    = 1'b0;
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_passthru_dir_ctrl.sv
// Randomized scoreboard bench for i2c_passthru_dir_ctrl.
// Watchdog timing is exercised when I2C_PASSTHRU_WDOG_EN is defined.
module tb_i2c_passthru_dir_ctrl;

    typedef struct packed {
        logic       slv;
        logic [3:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cha_scl, cha_sda, chb_scl, chb_sda;
    logic       rx_done, tx_done, rx_valid, rx_sda;
    logic       o_start, o_slv, o_busy, o_rd, o_af, o_rs, o_tmo;
    logic [3:0] o_cnt;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   starts  = 0;
    bit   ch      = 1'b0;

    always #5 clk = ~clk;

    i2c_passthru_dir_ctrl #(
        .DATA_BITS (8),
        .CNT_W     (4),
        .TMO_W     (16),
        .TMO_CYC   (100)
    ) dut (
        .i_clk               (clk),
        .i_rstn              (rst_n),
        .i_cha_scl           (cha_scl),
        .i_cha_sda           (cha_sda),
        .i_chb_scl           (chb_scl),
        .i_chb_sda           (chb_sda),
        .i_rx_done           (rx_done),
        .i_tx_done           (tx_done),
        .i_rx_sda_init_valid (rx_valid),
        .i_rx_sda_init       (rx_sda),
        .o_start             (o_start),
        .o_slv_is_rx         (o_slv),
        .o_busy              (o_busy),
        .o_bit_cnt           (o_cnt),
        .o_read_mode         (o_rd),
        .o_ack_failed        (o_af),
        .o_restart           (o_rs),
        .o_timeout           (o_tmo)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic scl, input logic sda);
        if (ch) begin
            chb_scl = scl;
            chb_sda = sda;
        end else begin
            cha_scl = scl;
            cha_sda = sda;
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (o_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (o_start !== 1'b1) begin
            vectors++;
            errors++;
            $display("FAIL wait_start: no o_start within 50 cycles at %0t",
                     $time);
        end
    endtask

    // Reference: byte 0 is the address (slave ACKs), later bytes follow
    // the R/W bit, and any NACK hands every remaining bit to the master.
    task automatic do_txn(input bit sr, input logic [7:0] addr,
                          input int nb, input logic [3:0] acks,
                          input bit keep);
        bit         nack;
        bit         slv;
        bit         last;
        logic [7:0] byt;
        logic       val;
        int         s0;
        exp_t       e;
        nack = 1'b0;
        byt  = addr;
        for (int k = 0; k < nb; k++) begin
            for (int b = 1; b <= 9; b++) begin
                if (k == 0)        slv = (b == 9);
                else if (nack)     slv = 1'b0;
                else if (!addr[0]) slv = (b == 9);
                else               slv = (b != 9);
                e.slv = slv;
                e.idx = 4'(b);
                sb.push_back(e);
            end
            if (acks[k]) nack = 1'b1;
        end
        s0 = starts;
        if (sr) begin
            drv(1'b0, 1'b1);
            @(negedge clk);
            drv(1'b1, 1'b1);
            @(negedge clk);
        end else begin
            drv(1'b1, 1'b1);
            @(negedge clk);
        end
        drv(1'b1, 1'b0);
        @(negedge clk);
        check("restart_pulse", o_rs, sr);
        check("cnt_after_start", o_cnt, 0);
        check("busy_after_start", o_busy, 1);
        check("rd_cleared", o_rd, 0);
        check("af_cleared", o_af, 0);
        drv(1'b0, 1'b0);
        for (int k = 0; k < nb; k++) begin
            for (int b = 1; b <= 9; b++) begin
                wait_start();
                rx_done = 1'b0;
                tx_done = 1'b0;
                if (k == 0 && b == 1) begin
                    @(negedge clk);
                    check("single_start", o_start, 0);
                    check("cnt_first_bit", o_cnt, 1);
                end
                repeat ($urandom_range(1, 3)) @(negedge clk);
                if (b == 1) byt = (k == 0) ? addr : 8'($urandom);
                val  = (b == 9) ? acks[k] : byt[8-b];
                last = (k == nb - 1) && (b == 9);
                rx_valid = 1'b1;
                rx_sda   = val;
                if (!last) begin
                    if ($urandom_range(0, 1) == 1) begin
                        rx_done = 1'b1;
                        @(negedge clk);
                        rx_valid = 1'b0;
                        check("one_done_holds", o_start, 0);
                    end
                    rx_done = 1'b1;
                    tx_done = 1'b1;
                end
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        check("read_mode", o_rd, addr[0]);
        check("ack_failed", o_af, nack);
        if (!keep) begin
            drv(1'b0, 1'b0);
            @(negedge clk);
            drv(1'b1, 1'b0);
            @(negedge clk);
            drv(1'b1, 1'b1);
            @(negedge clk);
            check("busy_after_stop", o_busy, 0);
            check("cnt_after_stop", o_cnt, 0);
            check("rd_held", o_rd, addr[0]);
            check("af_held", o_af, nack);
            check("no_timeout", o_tmo, 0);
            rx_done = 1'b1;
            tx_done = 1'b1;
        end
        check("start_count", starts - s0, 9 * nb);
    endtask

    // Monitor: every launch pops one expected bit
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_start === 1'b1) begin
                starts++;
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_start: queue empty, cnt=%0d at %0t",
                             o_cnt, $time);
                end else begin
                    e = sb.pop_front();
                    check("slv_is_rx", o_slv, e.slv);
                    @(negedge clk);
                    check("bit_cnt", o_cnt, e.idx);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bit         sr;
        bit         keep;
        bit         prev_keep;
        logic [7:0] addr;
        logic [3:0] acks;
        int         nb;
        int         n;
        exp_t       e;
        rst_n    = 1'b0;
        cha_scl  = 1'b1;
        cha_sda  = 1'b1;
        chb_scl  = 1'b1;
        chb_sda  = 1'b1;
        rx_done  = 1'b1;
        tx_done  = 1'b1;
        rx_valid = 1'b0;
        rx_sda   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {o_start, o_slv, o_busy, o_cnt, o_rd,
                              o_af, o_rs, o_tmo}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_txn(1'b0, 8'h50, 3, 4'b0000, 1'b0);
        do_txn(1'b0, 8'hA1, 3, 4'b0100, 1'b0);
        ch = 1'b1;
        do_txn(1'b0, 8'h3C, 3, 4'b0001, 1'b0);
        do_txn(1'b0, 8'h50, 2, 4'b0010, 1'b1);
        do_txn(1'b1, 8'hA1, 2, 4'b0010, 1'b0);

        prev_keep = 1'b0;
        for (int t = 0; t < 20; t++) begin
            sr = prev_keep && ($urandom_range(0, 1) == 1);
            if (prev_keep && !sr) begin
                drv(1'b1, 1'b0);
                @(negedge clk);
                drv(1'b1, 1'b1);
                @(negedge clk);
                rx_done = 1'b1;
                tx_done = 1'b1;
            end
            if (!sr) ch = 1'($urandom_range(0, 1));
            addr = 8'($urandom);
            nb   = $urandom_range(1, 4);
            acks = 4'b0000;
            acks[0] = ($urandom_range(0, 5) == 0);
            for (int k = 1; k < nb; k++) begin
                if (addr[0]) acks[k] = (k == nb - 1);
                else         acks[k] = ($urandom_range(0, 4) == 0);
            end
            keep = (t < 19) && ($urandom_range(0, 3) == 0);
            do_txn(sr, addr, nb, acks, keep);
            prev_keep = keep;
        end

        // Asynchronous reset in the middle of the first byte
        e.slv = 1'b0;
        e.idx = 4'd1;
        sb.push_back(e);
        drv(1'b1, 1'b1);
        @(negedge clk);
        drv(1'b1, 1'b0);
        @(negedge clk);
        drv(1'b0, 1'b0);
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_reset", o_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {o_start, o_slv, o_busy, o_cnt, o_rd,
                              o_af, o_rs, o_tmo}, 0);
        @(negedge clk);
        drv(1'b1, 1'b1);
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        n = starts;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", o_busy, 0);
        check("no_start_after_reset", starts - n, 0);

`ifdef I2C_PASSTHRU_WDOG_EN
        for (int b = 1; b <= 3; b++) begin
            e.slv = 1'b0;
            e.idx = 4'(b);
            sb.push_back(e);
        end
        drv(1'b1, 1'b1);
        @(negedge clk);
        drv(1'b1, 1'b0);
        @(negedge clk);
        drv(1'b0, 1'b0);
        for (int b = 1; b <= 3; b++) begin
            wait_start();
            rx_done = 1'b0;
            tx_done = 1'b0;
            if (b < 3) begin
                repeat (2) @(negedge clk);
                rx_done = 1'b1;
                tx_done = 1'b1;
                @(negedge clk);
            end
        end
        n = 0;
        while (o_tmo !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("timeout_delay", n, 100);
        check("timeout_busy", o_busy, 0);
        check("timeout_cnt", o_cnt, 0);
        @(negedge clk);
        check("timeout_pulse", o_tmo, 0);
        drv(1'b1, 1'b0);
        @(negedge clk);
        drv(1'b1, 1'b1);
        @(negedge clk);
        rx_done = 1'b1;
        tx_done = 1'b1;
        repeat (2) @(negedge clk);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
